// File: rtl/arb_pkg.sv
// Shared encodings and sizes for the round-robin 4:1 arbiter/mux.
// Holds the FSM state type and a select-to-one-hot helper.
package arb_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    function automatic logic [NREQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin winner search: first set request scanning up from ptr with wrap.
// Latency: combinational. Backpressure: none, pure function of req/ptr.
// found is low when no request bit is set; win then equals ptr.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] win
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

endmodule

// File: rtl/arb_rr_mux4.sv
// Round-robin arbiter driving a 4:1 mux: one owner at a time, bounded hold.
// Latency: grant registered 1 cycle after req; y is combinational from registered select.
// Backpressure: requesters hold req high until granted; owner keeps grant while req stays high.
module arb_rr_mux4
    import arb_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] select,
    output logic             busy,
    output logic [WIDTH-1:0] y
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t           state_q;
    logic [NREQ-1:0]  gnt_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] ptr_q;
    logic [3:0]       hold_q;

    logic [NREQ-1:0]  pick_req;
    logic             found;
    logic [SEL_W-1:0] win;
    logic             owner_req;
    logic             hold_end;
    logic             take_grant;

    // While owned, the current owner is masked so the same picker finds the successor.
    always_comb begin
        pick_req   = (state_q == OWNED) ? (req & ~gnt_q) : req;
        owner_req  = |(req & gnt_q);
        hold_end   = (hold_q == HOLD_LAST);
        take_grant = found && ((state_q == IDLE) || !owner_req || hold_end);
    end

    rr_pick4 u_pick (
        .req   (pick_req),
        .ptr   (ptr_q),
        .found (found),
        .win   (win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else if (take_grant) begin
            state_q <= OWNED;
            gnt_q   <= idx2onehot(win);
            sel_q   <= win;
            ptr_q   <= win + SEL_W'(1);
            hold_q  <= '0;
        end else if (state_q == OWNED) begin
            if (!owner_req) begin
                state_q <= IDLE;
                gnt_q   <= '0;
                hold_q  <= '0;
            end else if (hold_end) begin
                // Lone owner at the limit: keep the grant and restart the window.
                hold_q <= '0;
            end else begin
                hold_q <= hold_q + 4'd1;
            end
        end
    end

    assign gnt    = gnt_q;
    assign select = sel_q;
    assign busy   = (state_q == OWNED);

    always_comb begin
        y = '0;
        if (busy) begin
            case (sel_q)
                2'd0:    y = i0;
                2'd1:    y = i1;
                2'd2:    y = i2;
                default: y = i3;
            endcase
        end
    end

endmodule

// File: tb/tb_arb_rr_mux4.sv
// Directed bench for arb_rr_mux4: one instance at MAX_HOLD=4, one at MAX_HOLD=1.
module tb_arb_rr_mux4;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req4, req1;
    logic [W-1:0] d0, d1, d2, d3;

    logic [3:0]   gnt4, gnt1;
    logic [1:0]   sel4, sel1;
    logic         busy4, busy1;
    logic [W-1:0] y4, y1;

    typedef struct packed {
        int         u;
        logic [3:0] g;
        logic [1:0] s;
    } exp_t;

    exp_t  sb[$];
    string tagq[$];
    int    ntests = 0;
    int    nfail  = 0;

    arb_rr_mux4 #(.WIDTH(W), .MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4),
        .i0(d0), .i1(d1), .i2(d2), .i3(d3),
        .gnt(gnt4), .select(sel4), .busy(busy4), .y(y4)
    );

    arb_rr_mux4 #(.WIDTH(W), .MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1),
        .i0(d0), .i1(d1), .i2(d2), .i3(d3),
        .gnt(gnt1), .select(sel1), .busy(busy1), .y(y1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare();
        exp_t         e;
        string        tag;
        logic [3:0]   g;
        logic [1:0]   s;
        logic         b;
        logic [W-1:0] yv;
        logic         eb;
        logic [W-1:0] ey;
        e   = sb.pop_front();
        tag = tagq.pop_front();
        g   = (e.u == 0) ? gnt4  : gnt1;
        s   = (e.u == 0) ? sel4  : sel1;
        b   = (e.u == 0) ? busy4 : busy1;
        yv  = (e.u == 0) ? y4    : y1;
        eb  = (e.g != 4'b0000);
        ey  = '0;
        if (eb) begin
            case (e.s)
                2'd0:    ey = d0;
                2'd1:    ey = d1;
                2'd2:    ey = d2;
                default: ey = d3;
            endcase
        end
        ntests++;
        assert (g === e.g) else begin
            nfail++;
            $error("FAIL %s gnt: observed %b expected %b", tag, g, e.g);
        end
        ntests++;
        assert (s === e.s) else begin
            nfail++;
            $error("FAIL %s select: observed %0d expected %0d", tag, s, e.s);
        end
        ntests++;
        assert (b === eb) else begin
            nfail++;
            $error("FAIL %s busy: observed %b expected %b", tag, b, eb);
        end
        ntests++;
        assert (yv === ey) else begin
            nfail++;
            $error("FAIL %s y: observed %h expected %h", tag, yv, ey);
        end
    endtask

    // Drive req for one cycle; expected outputs are checked just after the edge.
    task automatic step(input int u, input logic [3:0] r, input logic [3:0] g,
                        input logic [1:0] s, input string tag);
        if (u == 0) req4 = r;
        else        req1 = r;
        sb.push_back('{u: u, g: g, s: s});
        tagq.push_back(tag);
        @(posedge clk);
        #1;
        compare();
    endtask

    // Check without a clock edge (reset assertion, combinational pass-through).
    task automatic now(input int u, input logic [3:0] g, input logic [1:0] s,
                       input string tag);
        sb.push_back('{u: u, g: g, s: s});
        tagq.push_back(tag);
        compare();
    endtask

    initial begin
        rst_n = 1'b0;
        req4  = 4'b0000;
        req1  = 4'b0000;
        d0 = 8'h11; d1 = 8'h22; d2 = 8'h33; d3 = 8'h44;
        #12;
        now(0, 4'b0000, 2'd0, "reset4");
        now(1, 4'b0000, 2'd0, "reset1");
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, then drop: select holds its last value in IDLE.
        step(0, 4'b0100, 4'b0100, 2'd2, "single_gnt");
        step(0, 4'b0000, 4'b0000, 2'd2, "single_drop");

        // Hold limit 4 with two contenders (ptr=3, so requester 0 wins first).
        for (int k = 0; k < 4; k++) step(0, 4'b0011, 4'b0001, 2'd0, "hold_own0");
        for (int k = 0; k < 4; k++) step(0, 4'b0011, 4'b0010, 2'd1, "hold_own1");
        step(0, 4'b0011, 4'b0001, 2'd0, "hold_back0");
        step(0, 4'b0000, 4'b0000, 2'd0, "hold_idle");

        // Lone owner keeps the grant across several hold wraps.
        for (int k = 0; k < 10; k++) step(0, 4'b1000, 4'b1000, 2'd3, "lone");
        step(0, 4'b0000, 4'b0000, 2'd3, "lone_idle");

        // Owner 1 drops req exactly at hold expiry with ptr=2 and 0101 pending.
        step(0, 4'b0010, 4'b0010, 2'd1, "sim_gnt1");
        for (int k = 0; k < 3; k++) step(0, 4'b0111, 4'b0010, 2'd1, "sim_hold");
        step(0, 4'b0101, 4'b0100, 2'd2, "sim_next");

        // Data pass-through while owned, no clock edge.
        d2 = 8'h5A;
        #1;
        now(0, 4'b0100, 2'd2, "pass_through");

        // Asynchronous reset mid-ownership.
        rst_n = 1'b0;
        #1;
        now(0, 4'b0000, 2'd0, "reset_mid");
        req4 = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        // Rotation with MAX_HOLD=1 and all four requesting.
        step(1, 4'b1111, 4'b0001, 2'd0, "rot0");
        step(1, 4'b1111, 4'b0010, 2'd1, "rot1");
        step(1, 4'b1111, 4'b0100, 2'd2, "rot2");
        step(1, 4'b1111, 4'b1000, 2'd3, "rot3");
        step(1, 4'b1111, 4'b0001, 2'd0, "rot_wrap");
        step(1, 4'b0000, 4'b0000, 2'd0, "rot_idle");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/arb_rr_mux4.md
# arb_rr_mux4

Round-robin arbiter and controller for the 4:1 multiplexer datapath. Shares one output channel among four requesters: picks one requester, drives the mux select, presents that requester's data on `y`, and rotates priority so no requester starves. Sits between four producer blocks and a single consumer, replacing a fixed, externally driven `select`.

## Interface
- `WIDTH`, 1: data width of each mux input and of `y`.
- `MAX_HOLD`, 4: maximum consecutive cycles one owner keeps the grant while others wait; legal range 1..15.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req` in 4: request per requester; level, held high while the requester wants the channel.
- `i0`, `i1`, `i2`, `i3` in WIDTH: requester data inputs.
- `gnt` out 4: one-hot grant, registered; all zero when idle.
- `select` out 2: registered mux select, index of the current owner.
- `busy` out 1: high while any grant is active.
- `y` out WIDTH: `i[select]` when `busy`, else all zero; combinational from registered `select` and `busy`.

## Operation
- State machine with two states: IDLE, OWNED.
- IDLE: `gnt`=0, `busy`=0. If any `req` bit is high at a rising edge, move to OWNED, grant the winner.
- Winner: the first set `req` bit scanning upward from `ptr` with wrap (`ptr`, `ptr`+1, ... mod 4).
- On every grant, `ptr` <= winner+1 mod 4, so the new owner becomes lowest priority next time.
- OWNED: `hold` counter (4 bits) counts cycles of the current ownership, starting at 0 on the grant edge.
- Release conditions, evaluated each edge in OWNED:
  - owner's `req` low: release. If other requests are pending, grant the next winner on the same edge; otherwise go to IDLE.
  - `hold` == MAX_HOLD-1 and any other `req` high: forced release, next winner granted on the same edge.
  - `hold` == MAX_HOLD-1 and no other request: owner keeps the grant, `hold` restarts at 0, `ptr` unchanged.
- Owner's `req` and others sampled together; owner release takes precedence over hold expiry.
- `select` updates on the same edge as `gnt`; in IDLE `select` holds its last value.

## Timing
- Reset (async assert, sync deassert expected from the system): `gnt`=0000, `select`=00, `busy`=0, `y`=0, `ptr`=0, `hold`=0, state IDLE.
- Grant latency: `req` high before edge N, then `gnt`/`select`/`busy` valid after edge N (1 cycle).
- Handover: zero idle cycles between owners when a request is pending; old and new grant never both high.
- Idle gap: owner drops `req` with no other pending, then `busy` low after the next edge.
- Requester must not drop `req` mid-transfer except to end its ownership; a requester re-raising `req` is treated as new.
- `rst_n` asserted mid-ownership: outputs go to reset values immediately, with no clock needed.
- `y` changes only through `select`/`busy` (registered) or through `i*` (combinational pass-through).

## Structure
- Shared package `arb_pkg`: state encoding constants (IDLE=1'b0, OWNED=1'b1), `NREQ`=4, select width 2.
- One sub-module: `rr_pick4`, combinational, taking `req` and `ptr` and returning `found` and the 2-bit winner index. It is reused for both idle-grant and handover.
- Data path: behavioural 4:1 select inside the top, gated by `busy`.

## Test plan
- Reset: assert `rst_n`=0 mid-grant, which requires `gnt`=0000, `select`=00, `busy`=0, `y`=0 with no clock edge.
- Single requester: `req`=0100, `i2`=1, giving `gnt`=0100, `select`=10, `y`=1 one cycle later. Drop `req`: `busy`=0 next edge.
- Rotation: `req`=1111 held, MAX_HOLD=1. Grants cycle 0001→0010→0100→1000→0001, one per cycle.
- Hold limit: MAX_HOLD=4, `req`=0011. Owner 0 holds 4 cycles, then `gnt`=0010 with no gap. Owner 1 holds 4, then returns to 0.
- Lone owner: `req`=1000 for 10 cycles. `gnt` stays 1000 throughout and `hold` wraps without a glitch.
- Simultaneous: owner 1 drops `req` on the same edge that `hold` expires, with `req`=0101 pending and `ptr`=2. Next grant is 0100.
